// File: rtl/fsm_counter_pkg.sv
// Shared types and defaults for the run-length controller.
package fsm_counter_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    DONE     = 2'b10,
    PAUSED   = 2'b11
  } ctrl_state_t;

endpackage

// File: rtl/fsm_counter_ctrl_term_counter.sv
// Up-counter with synchronous clear/enable and a combinational terminal flag.
module term_counter
  import fsm_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit_q,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  // Count register: clear wins over enable; holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal flag compares against the latched limit only.
  always_comb begin
    at_term = (count == limit_q);
  end

endmodule

// File: rtl/fsm_counter_ctrl.sv
// Run-length controller: counts 0..limit on go, one-shot or auto-reload,
// with pause/resume, abort and DONE acknowledge.
module fsm_counter_ctrl
  import fsm_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [CNT_W-1:0] limit,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  ctrl_state_t      state;
  logic [CNT_W-1:0] limit_q;
  logic             mode_q;
  logic             at_term;
  logic             cnt_clear;
  logic             cnt_enable;

  // Counter controls derived from the current state and inputs, honouring
  // abort > ack > pause > terminal/increment > go.
  always_comb begin
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clear = go && !abort;
      end
      COUNTING: begin
        if (abort) begin
          cnt_clear = 1'b1;
        end else if (!pause) begin
          if (at_term) begin
            cnt_clear = mode_q;
          end else begin
            cnt_enable = 1'b1;
          end
        end
      end
      PAUSED: begin
        cnt_clear = abort;
      end
      DONE: begin
        cnt_clear = abort || ack;
      end
      default: begin
        cnt_clear = 1'b1;
      end
    endcase
  end

  term_counter #(
    .CNT_W(CNT_W)
  ) u_term_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit_q (limit_q),
    .count   (count),
    .at_term (at_term)
  );

  // Control FSM with registered busy/done/tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      limit_q <= '0;
      mode_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go && !abort) begin
            state   <= COUNTING;
            limit_q <= limit;
            mode_q  <= auto_reload;
            busy    <= 1'b1;
          end
        end
        COUNTING: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pause) begin
            state <= PAUSED;
          end else if (at_term) begin
            tick <= 1'b1;
            if (!mode_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!pause) begin
            state <= COUNTING;
          end
        end
        DONE: begin
          if (abort || ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// Directed bench for fsm_counter_ctrl with hand-computed expectations.
module tb_fsm_counter_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic [CNT_W-1:0] limit;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic             ack;
  logic             busy;
  logic             done;
  logic             tick;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  fsm_counter_ctrl #(
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .limit       (limit),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .ack         (ack),
    .busy        (busy),
    .done        (done),
    .tick        (tick),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic b, input logic d,
                            input logic t, input int unsigned c);
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".done"},  32'(done),  32'(d));
    check({tag, ".tick"},  32'(tick),  32'(t));
    check({tag, ".count"}, 32'(count), 32'(c));
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; limit = '0; auto_reload = 1'b0;
    pause = 1'b0; abort = 1'b0; ack = 1'b0;
    #12;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 0);
    #10 rst = 1'b0;
    step();
    check_outs("post_reset", 1'b0, 1'b0, 1'b0, 0);

    // One-shot, limit 5; limit changed mid-run must be ignored.
    limit = 8'd5; auto_reload = 1'b0; go = 1'b1;
    step();
    go = 1'b0; limit = 8'd1; auto_reload = 1'b1;
    check_outs("os_e0", 1'b1, 1'b0, 1'b0, 0);
    for (int unsigned j = 1; j <= 5; j++) begin
      step();
      check_outs("os_run", 1'b1, 1'b0, 1'b0, j);
    end
    step();
    check_outs("os_term", 1'b0, 1'b1, 1'b1, 5);
    step();
    check_outs("os_hold", 1'b0, 1'b1, 1'b0, 5);
    // go + ack in DONE returns to IDLE only.
    go = 1'b1; ack = 1'b1;
    step();
    go = 1'b0; ack = 1'b0;
    check_outs("goack", 1'b0, 1'b0, 1'b0, 0);
    step();
    check_outs("goack_idle", 1'b0, 1'b0, 1'b0, 0);

    // Reload, limit 3: tick every 4 cycles; go mid-run ignored; abort at terminal.
    limit = 8'd3; auto_reload = 1'b1; go = 1'b1;
    step();
    go = 1'b0;
    check_outs("rl_e0", 1'b1, 1'b0, 1'b0, 0);
    for (int unsigned e = 1; e <= 15; e++) begin
      if (e == 5) begin
        go = 1'b1; limit = 8'd7;
      end else begin
        go = 1'b0;
      end
      step();
      check_outs("rl_run", 1'b1, 1'b0, ((e % 4) == 0), e % 4);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_outs("rl_abort", 1'b0, 1'b0, 1'b0, 0);
    step();
    check_outs("rl_abort_idle", 1'b0, 1'b0, 1'b0, 0);

    // Pause for 3 cycles at count 2 with limit 4: terminal moves from edge 5 to 9.
    limit = 8'd4; auto_reload = 1'b0; go = 1'b1;
    step();
    go = 1'b0;
    step(); check_outs("p_e1", 1'b1, 1'b0, 1'b0, 1);
    step(); check_outs("p_e2", 1'b1, 1'b0, 1'b0, 2);
    pause = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step(); check_outs("p_frozen", 1'b1, 1'b0, 1'b0, 2);
    end
    pause = 1'b0;
    step(); check_outs("p_resume", 1'b1, 1'b0, 1'b0, 2);
    step(); check_outs("p_e7", 1'b1, 1'b0, 1'b0, 3);
    step(); check_outs("p_e8", 1'b1, 1'b0, 1'b0, 4);
    step(); check_outs("p_term", 1'b0, 1'b1, 1'b1, 4);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_outs("p_ack", 1'b0, 1'b0, 1'b0, 0);

    // limit 0: done after edge 1.
    limit = 8'd0; go = 1'b1;
    step();
    go = 1'b0;
    check_outs("l0_e0", 1'b1, 1'b0, 1'b0, 0);
    step();
    check_outs("l0_term", 1'b0, 1'b1, 1'b1, 0);
    ack = 1'b1; step(); ack = 1'b0;

    // limit 255: done after edge 256, no wrap.
    limit = 8'd255; go = 1'b1;
    step();
    go = 1'b0;
    repeat (255) step();
    check_outs("l255_e255", 1'b1, 1'b0, 1'b0, 255);
    step();
    check_outs("l255_term", 1'b0, 1'b1, 1'b1, 255);
    ack = 1'b1; step(); ack = 1'b0;
    check_outs("l255_ack", 1'b0, 1'b0, 1'b0, 0);

    // go + abort in IDLE stays IDLE.
    limit = 8'd2; go = 1'b1; abort = 1'b1;
    step();
    go = 1'b0; abort = 1'b0;
    check_outs("goabort", 1'b0, 1'b0, 1'b0, 0);
    step();
    check_outs("goabort_idle", 1'b0, 1'b0, 1'b0, 0);

    // Async reset mid-COUNTING, off an edge.
    limit = 8'd10; go = 1'b1;
    step();
    go = 1'b0;
    step(); step();
    check_outs("ar_pre", 1'b1, 1'b0, 1'b0, 2);
    #2 rst = 1'b1;
    #1;
    check_outs("ar_async", 1'b0, 1'b0, 1'b0, 0);
    #3 rst = 1'b0;
    step(); step();
    check_outs("ar_quiet", 1'b0, 1'b0, 1'b0, 0);
    limit = 8'd1; go = 1'b1;
    step();
    go = 1'b0;
    check_outs("ar_restart", 1'b1, 1'b0, 1'b0, 0);
    step();
    check_outs("ar_r1", 1'b1, 1'b0, 1'b0, 1);
    step();
    check_outs("ar_rterm", 1'b0, 1'b1, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_counter_ctrl.md
# fsm_counter_ctrl

Parametrised run-length controller: on `go` it counts from 0 up to a programmable limit, then either stops in DONE or auto-reloads. It also supports pause/resume, abort and a DONE acknowledge. It is the generalised replacement for the fixed 4-bit one-shot sequencer and sits between control software registers and datapath blocks that need a timed "busy" window.

## Interface
- `CNT_W`, default 8: counter and limit width (≥1).
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `go`  in  1  start request; accepted only in IDLE.
- `limit`  in  CNT_W  terminal count; sampled into `limit_q` when `go` is accepted.
- `auto_reload`  in  1  mode; sampled into `mode_q` when `go` is accepted (0 = one-shot, 1 = reload).
- `pause`  in  1  level; freezes counting while high.
- `abort`  in  1  return to IDLE from any state.
- `ack`  in  1  clears DONE.
- `busy`  out  1  high in COUNTING or PAUSED.
- `done`  out  1  high in DONE.
- `tick`  out  1  one-cycle pulse per terminal count reached.
- `count`  out  CNT_W  current count.

## Operation
- States: IDLE, COUNTING, PAUSED, DONE.
- Priority per edge: `abort` > `ack` > `pause` > terminal/increment > `go`.
- IDLE:
  - `go`=1 (and `abort`=0) → COUNTING; `count`<=0; latch `limit_q`, `mode_q`.
  - `pause` and `ack` are ignored.
- COUNTING:
  - `pause`=1 → PAUSED; `count` holds; terminal check suppressed.
  - Else if `count`==`limit_q`:
    - `tick`<=1.
    - One-shot → DONE, `count` holds at `limit_q`.
    - Reload → stay in COUNTING, `count`<=0.
  - Else `count`<=`count`+1.
- PAUSED:
  - `pause`=0 → COUNTING; `count` is not advanced on the resume edge.
  - `pause`=1 → stay.
- DONE:
  - `ack`=1 → IDLE, `count`<=0.
  - Otherwise hold.
- `abort` in any non-IDLE state → IDLE, `count`<=0, no `tick`.
- `go` outside IDLE is ignored; there is no queuing.
- `go`+`ack` together in DONE → IDLE only; `go` must be re-asserted.
- Changes to `limit` and `auto_reload` after `go` is accepted have no effect until the next start.
- Arithmetic: unsigned CNT_W bits. `count` never exceeds `limit_q`, so no wrap occurs.
  - `limit`=0: one COUNTING cycle, then terminal.
  - `limit`=2^CNT_W−1 is legal.

## Timing
- Reset values: state IDLE, `count`=0, `limit_q`=0, `mode_q`=0, `busy`=0, `done`=0, `tick`=0.
- All outputs are registered or decoded directly from the state register (Moore). No input-to-output combinational path.
- `go` sampled at edge 0 → `busy`=1 and `count`=0 after edge 0.
- After edge j, `count`=j for j ≤ L (`limit_q`=L, no pause).
- Terminal edge is L+1:
  - `tick`=1 for exactly that following cycle.
  - One-shot: `done`=1 and `busy`=0 after that edge.
- Each cycle spent in PAUSED, plus the resume edge, adds one cycle of latency.
- Reload mode: `tick` period is L+1 cycles.
- Reset asserted mid-operation forces the reset values immediately (asynchronously). Operation restarts only on a new `go` after `rst` is released.

## Structure
- Package `fsm_counter_pkg`:
  - `ctrl_state_t`, 2-bit enum: IDLE=00, COUNTING=01, DONE=10, PAUSED=11.
  - Default `CNT_W` constant.
- Sub-module `term_counter`, parametrised by `CNT_W`:
  - Inputs: clear, enable, `limit_q`.
  - Outputs: `count` and combinational `at_term`.
- The FSM and the `tick`/`busy`/`done` registers live in the top level.

## Test plan
- `CNT_W`=8, `limit`=5, one-shot, `go` at edge 0 → `count` 0..5, `tick` pulse and `done`=1 after edge 6; `done` held until `ack`, then IDLE with `count`=0.
- `limit`=3, reload → `tick` every 4 cycles for 3 periods with `busy` constant 1; `abort` → IDLE within one edge with no `tick`.
- `limit`=4, `pause` high for 3 cycles at `count`=2 → `count` frozen at 2 during pause plus the resume edge; `done` delayed by 4 cycles versus the no-pause run.
- Boundaries:
  - `limit`=0 → `done` after edge 1.
  - `limit`=255 → `done` after edge 256, `count` ends at 255 with no wrap.
- Simultaneous events:
  - `go`+`abort` in IDLE → stays IDLE.
  - `go`+`ack` in DONE → IDLE only.
  - `go` during COUNTING → ignored.
  - `limit` changed mid-run → ignored.
- Async `rst` pulsed mid-COUNTING, off a clock edge → all outputs 0 immediately; no activity until the next `go`.
